servo_move_arbiter: RTL and testbench
=====================================

# servo_move_arbiter

Sequences and shares the single servo PWM channel between `NUM_REQ` independent move requesters, e.g. the register-mapped processor path and a manual or test path. A granted requester's duty-cycle command is clamped and driven to the PWM driver for a hold interval. The arbiter then drives neutral for a settle interval and reports completion before it accepts the next request. It sits between the requesters and the servo PWM driver, replacing ad-hoc per-case duty selection with a single owner of `duty_cycle`.

## Interface
Parameters:
- `NUM_REQ`, 2 — number of requesters, 2..4.
- `HOLD_CYCLES`, 80000000 — cycles a timed move holds its duty (3.2 s at 25 MHz).
- `SETTLE_CYCLES`, 12500000 — cycles neutral is held after any move (0.5 s).
- `NEUTRAL_DUTY`, 45 — centre duty code.
- `MIN_DUTY`, 20 / `MAX_DUTY`, 70 — clamp limits.

Ports:
- `clk25mhz`  in  1  — the only clock, 25 MHz.
- `reset`  in  1  — asynchronous, active-low reset.
- `req`  in  NUM_REQ  — level move requests.
- `req_duty`  in  10*NUM_REQ  — target duty per requester; slice i is `[10i+9:10i]`.
- `req_latch`  in  NUM_REQ  — 1 = hold while `req` stays high; 0 = timed move.
- `grant`  out  NUM_REQ  — one-hot owner; high from MOVE entry through end of SETTLE.
- `done`  out  NUM_REQ  — one-cycle pulse to the owner at the last SETTLE cycle.
- `duty_cycle`  out  10  — to PWM driver `duty_cycle_input`.
- `busy`  out  1  — high in any state other than IDLE.
- `state_dbg`  out  2  — current state encoding for the debug header.

## Operation
- States: IDLE=0, MOVE=1, SETTLE=2.
- **IDLE:**
  - If any `req` is high, the round-robin arbiter picks winner w.
  - Next edge: `grant[w]`=1; `duty_cycle` = clamp(`req_duty[w]`); `req_latch[w]` is captured; counter=0; → MOVE.
- **Round-robin:**
  - Search starts at pointer p; p resets to 0.
  - On each grant, p ← (w+1) mod NUM_REQ.
- **Clamp:** values below `MIN_DUTY` map to `MIN_DUTY`; values above `MAX_DUTY` map to `MAX_DUTY`. `req_duty` is sampled once at grant; later changes are ignored.
- **MOVE, timed (latch=0):**
  - Counter increments each cycle.
  - At counter = HOLD_CYCLES−1: `duty_cycle` ← NEUTRAL; counter=0; → SETTLE.
  - Deasserting `req` mid-move is ignored.
- **MOVE, latched (latch=1):**
  - Stays in MOVE while `req[w]`=1. There is no timeout; the counter holds at 0.
  - The first cycle `req[w]`=0 is seen: → SETTLE with neutral duty.
- **SETTLE:**
  - Counter increments each cycle.
  - At counter = SETTLE_CYCLES−1: `done[w]` pulses, `grant` clears, → IDLE.
- **Re-requests:** a requester still asserting `req` after `done` is re-arbitrated normally, so round-robin gives others priority.
- **Counter:** width `$clog2(max(HOLD_CYCLES,SETTLE_CYCLES)+1)`; it never wraps.
- **Reset values (async, any state):**
  - Outputs: `duty_cycle`=NEUTRAL_DUTY, `grant`=0, `done`=0, `busy`=0, `state_dbg`=0.
  - Internal: state=IDLE, counter=0, p=0.

## Timing
- `req` rising edge in IDLE → `grant` and new `duty_cycle` visible 1 cycle later.
- Timed move: duty held exactly HOLD_CYCLES cycles, then neutral exactly SETTLE_CYCLES cycles.
- `done` is coincident with the last SETTLE cycle. IDLE lasts at least 1 cycle between moves, so the minimum grant-to-grant spacing is HOLD+SETTLE+1 cycles.
- Latched release: `req[w]` low at edge k → neutral duty at edge k+1.
- Simultaneous requests are resolved in the same IDLE cycle; requests arriving during MOVE or SETTLE wait.
- All outputs are registered; there are no combinational paths from `req` to any output.

## Structure
- Package `servo_pkg` holds:
  - the state enum (IDLE/MOVE/SETTLE);
  - `NEUTRAL_DUTY`, `MIN_DUTY`, `MAX_DUTY` defaults;
  - the `DUTY_W`=10 constant, shared with the PWM driver and register I/O.
- Sub-module `rr_arbiter`:
  - parameter `N`; inputs `req`, `ptr`, `en`;
  - outputs one-hot `gnt` and index `gnt_idx`.
- The top level holds the FSM, counter, clamp, and output registers.

## Test plan
Use simulation parameters HOLD_CYCLES=10, SETTLE_CYCLES=4, NUM_REQ=2.
1. `req[0]`, duty 60, latch 0 → `grant`=01 next cycle; duty=60 for 10 cycles, 45 for 4 cycles; `done[0]` pulse on the 4th; `busy` low after.
2. `req`=11 in the same cycle with duties 30/65, after reset → req0 served first with 30; req1 granted 1 cycle after `done[0]` with 65. Hold both high: the third grant goes to req0.
3. `req_duty`=5 then 900 → `duty_cycle`=20, then 70.
4. Latched req1, duty 25, held 50 cycles then dropped at edge k → duty 25 through edge k, 45 at k+1, `done[1]` 4 cycles later.
5. Assert `reset`=0 mid-MOVE (duty 60) → immediately `duty_cycle`=45, `grant`=0, `busy`=0. After release with `req[0]` high, a fresh full move starts.
6. Toggle `req[1]` during req0's timed MOVE and SETTLE → no effect on `duty_cycle`; req1 is granted only after `done[0]` if it is still high.

Source files
------------

// File: rtl/servo_move_arbiter_pkg.sv
// Shared types and constants for the servo move arbiter and the PWM/register path.
package servo_pkg;

    localparam int DUTY_W = 10;

    localparam int DFLT_NEUTRAL_DUTY = 45;
    localparam int DFLT_MIN_DUTY     = 20;
    localparam int DFLT_MAX_DUTY     = 70;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MOVE   = 2'd1,
        S_SETTLE = 2'd2
    } servo_state_e;

    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] d,
        input logic [DUTY_W-1:0] lo,
        input logic [DUTY_W-1:0] hi
    );
        if (d < lo)      return lo;
        else if (d > hi) return hi;
        else             return d;
    endfunction

endpackage

// File: rtl/servo_move_arbiter_if.sv
// Requester-side bundle of the servo move arbiter: level requests in, grant/done/duty out.
interface servo_move_arbiter_if
    import servo_pkg::*;
#(
    parameter int NUM_REQ = 2
);
    // Handshake: req[i] is a level request; it is accepted on the edge that raises
    // grant[i]; grant[i] stays high until the edge after done[i] pulses.
    logic [NUM_REQ-1:0]        req;
    logic [DUTY_W*NUM_REQ-1:0] req_duty;
    logic [NUM_REQ-1:0]        req_latch;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        done;
    logic [DUTY_W-1:0]         duty_cycle;
    logic                      busy;
    logic [1:0]                state_dbg;

    modport master (
        output req, req_duty, req_latch,
        input  grant, done, duty_cycle, busy, state_dbg
    );

    modport slave (
        input  req, req_duty, req_latch,
        output grant, done, duty_cycle, busy, state_dbg
    );

endinterface

// File: rtl/servo_move_arbiter_rr_arbiter.sv
// Round-robin pick: first active request at or after ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic          found;
    logic [PW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            cand = PW'((int'(ptr) + k) % N);
            if (en && !found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/servo_move_arbiter.sv
// Single owner of the servo duty command: grants one requester at a time, holds its
// clamped duty (timed or latched), then settles at neutral before the next grant.
module servo_move_arbiter
    import servo_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int HOLD_CYCLES   = 80000000,
    parameter int SETTLE_CYCLES = 12500000,
    parameter int NEUTRAL_DUTY  = DFLT_NEUTRAL_DUTY,
    parameter int MIN_DUTY      = DFLT_MIN_DUTY,
    parameter int MAX_DUTY      = DFLT_MAX_DUTY
) (
    input  logic                 clk25mhz,
    input  logic                 reset,
    servo_move_arbiter_if.slave  bus
);

    localparam int MAX_CNT = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    // done is registered, so it is armed one cycle before the last settle cycle.
    localparam logic [CW-1:0] SETTLE_PEN  = CW'((SETTLE_CYCLES >= 2) ? SETTLE_CYCLES - 2 : 0);
    localparam bit            SETTLE_ONE  = (SETTLE_CYCLES == 1);

    localparam logic [DUTY_W-1:0] NEUTRAL = DUTY_W'(NEUTRAL_DUTY);
    localparam logic [DUTY_W-1:0] LO      = DUTY_W'(MIN_DUTY);
    localparam logic [DUTY_W-1:0] HI      = DUTY_W'(MAX_DUTY);

    servo_state_e         state;
    logic [CW-1:0]        cnt;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        owner;
    logic                 latch_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [DUTY_W-1:0]    duty_q;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [PW-1:0]        arb_idx;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_arb (
        .req     (bus.req),
        .ptr     (ptr),
        .en      (state == S_IDLE),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    always_ff @(posedge clk25mhz or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            owner   <= '0;
            latch_q <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
            duty_q  <= NEUTRAL;
        end else begin
            done_q <= '0;
            case (state)
                S_IDLE: begin
                    if (|arb_gnt) begin
                        grant_q <= arb_gnt;
                        owner   <= arb_idx;
                        latch_q <= bus.req_latch[arb_idx];
                        duty_q  <= clamp_duty(bus.req_duty[int'(arb_idx)*DUTY_W +: DUTY_W], LO, HI);
                        cnt     <= '0;
                        ptr     <= (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        state   <= S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (latch_q ? !bus.req[owner] : (cnt == HOLD_LAST)) begin
                        duty_q <= NEUTRAL;
                        cnt    <= '0;
                        state  <= S_SETTLE;
                        if (SETTLE_ONE) done_q <= grant_q;
                    end else if (!latch_q) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (cnt == SETTLE_LAST) begin
                        grant_q <= '0;
                        cnt     <= '0;
                        state   <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (!SETTLE_ONE && cnt == SETTLE_PEN) done_q <= grant_q;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.done       = done_q;
    assign bus.duty_cycle = duty_q;
    assign bus.busy       = (state != S_IDLE);
    assign bus.state_dbg  = state;

endmodule

// File: tb/tb_servo_move_arbiter.sv
// Directed bench for servo_move_arbiter with HOLD=10, SETTLE=4, two requesters.
module tb_servo_move_arbiter;
    import servo_pkg::*;

    localparam int NR     = 2;
    localparam int HOLD   = 10;
    localparam int SETTLE = 4;

    logic clk25mhz = 1'b0;
    logic reset    = 1'b1;

    always #20 clk25mhz = ~clk25mhz;

    servo_move_arbiter_if #(.NUM_REQ(NR)) bus ();

    servo_move_arbiter #(
        .NUM_REQ       (NR),
        .HOLD_CYCLES   (HOLD),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk25mhz (clk25mhz),
        .reset    (reset),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values();
        check_val("rst_duty",  32'(bus.duty_cycle), 32'd45);
        check_val("rst_grant", 32'(bus.grant),      32'd0);
        check_val("rst_done",  32'(bus.done),       32'd0);
        check_val("rst_busy",  32'(bus.busy),       32'd0);
        check_val("rst_state", 32'(bus.state_dbg),  32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk25mhz);
        reset = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk25mhz);
        reset = 1'b1;
    endtask

    // Called on the first cycle grant is visible; returns on the first IDLE cycle.
    task automatic check_timed_move(input logic [1:0] g, input logic [9:0] d, input bit tog);
        exp_q.delete();
        for (int i = 0; i < HOLD; i++)   exp_q.push_back(d);
        for (int i = 0; i < SETTLE; i++) exp_q.push_back(10'd45);
        for (int c = 1; c <= HOLD + SETTLE; c++) begin
            check_val("mv_duty",  32'(bus.duty_cycle), 32'(exp_q.pop_front()));
            check_val("mv_grant", 32'(bus.grant),      32'(g));
            check_val("mv_done",  32'(bus.done),       (c == HOLD + SETTLE) ? 32'(g) : 32'd0);
            check_val("mv_busy",  32'(bus.busy),       32'd1);
            check_val("mv_state", 32'(bus.state_dbg),  (c <= HOLD) ? 32'd1 : 32'd2);
            if (tog) begin
                bus.req[1]         = (c == HOLD + SETTLE) ? 1'b1 : c[0];
                bus.req_duty[9:0]  = 10'(c * 37);
            end
            @(negedge clk25mhz);
        end
        check_val("end_grant", 32'(bus.grant),      32'd0);
        check_val("end_busy",  32'(bus.busy),       32'd0);
        check_val("end_done",  32'(bus.done),       32'd0);
        check_val("end_state", 32'(bus.state_dbg),  32'd0);
        check_val("end_duty",  32'(bus.duty_cycle), 32'd45);
    endtask

    initial begin
        bus.req       = '0;
        bus.req_duty  = '0;
        bus.req_latch = '0;
        #5 reset = 1'b0;
        #1 check_reset_values();
        @(negedge clk25mhz);
        @(negedge clk25mhz);
        reset = 1'b1;

        // Timed move on req0, request dropped mid-move.
        @(negedge clk25mhz);
        bus.req_duty[9:0] = 10'd60;
        bus.req           = 2'b01;
        @(negedge clk25mhz);
        bus.req = 2'b00;
        check_timed_move(2'b01, 10'd60, 1'b0);

        // Simultaneous requests after reset: 0, then 1, then 0 again.
        apply_reset();
        bus.req_duty = {10'd65, 10'd30};
        bus.req      = 2'b11;
        @(negedge clk25mhz);
        check_timed_move(2'b01, 10'd30, 1'b0);
        @(negedge clk25mhz);
        check_timed_move(2'b10, 10'd65, 1'b0);
        @(negedge clk25mhz);
        check_timed_move(2'b01, 10'd30, 1'b0);
        bus.req = 2'b00;

        // Clamp limits.
        bus.req_duty[9:0] = 10'd5;
        bus.req           = 2'b01;
        @(negedge clk25mhz);
        bus.req = 2'b00;
        check_timed_move(2'b01, 10'd20, 1'b0);
        bus.req_duty[9:0] = 10'd900;
        bus.req           = 2'b01;
        @(negedge clk25mhz);
        bus.req = 2'b00;
        check_timed_move(2'b01, 10'd70, 1'b0);

        // Latched move on req1 held 50 cycles, past the timed hold.
        bus.req_duty[19:10] = 10'd25;
        bus.req_latch       = 2'b10;
        bus.req             = 2'b10;
        @(negedge clk25mhz);
        for (int c = 0; c < 50; c++) begin
            check_val("lat_duty",  32'(bus.duty_cycle), 32'd25);
            check_val("lat_grant", 32'(bus.grant),      32'd2);
            check_val("lat_state", 32'(bus.state_dbg),  32'd1);
            if (c < 49) @(negedge clk25mhz);
        end
        bus.req = 2'b00;
        for (int s = 1; s <= 5; s++) begin
            @(negedge clk25mhz);
            if (s <= 4) begin
                check_val("rel_duty",  32'(bus.duty_cycle), 32'd45);
                check_val("rel_grant", 32'(bus.grant),      32'd2);
                check_val("rel_state", 32'(bus.state_dbg),  32'd2);
                check_val("rel_done",  32'(bus.done),       (s == 4) ? 32'd2 : 32'd0);
            end else begin
                check_val("rel_idle_grant", 32'(bus.grant),     32'd0);
                check_val("rel_idle_busy",  32'(bus.busy),      32'd0);
                check_val("rel_idle_done",  32'(bus.done),      32'd0);
                check_val("rel_idle_state", 32'(bus.state_dbg), 32'd0);
            end
        end
        bus.req_latch = 2'b00;

        // Reset in the middle of a timed move, then a fresh full move.
        bus.req_duty[9:0] = 10'd60;
        bus.req           = 2'b01;
        @(negedge clk25mhz);
        check_val("pre_rst_grant", 32'(bus.grant),      32'd1);
        check_val("pre_rst_duty",  32'(bus.duty_cycle), 32'd60);
        repeat (3) @(negedge clk25mhz);
        reset = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk25mhz);
        reset = 1'b1;
        @(negedge clk25mhz);
        bus.req = 2'b00;
        check_timed_move(2'b01, 10'd60, 1'b0);

        // req1 toggling during req0's move; granted only after done[0].
        bus.req_duty = {10'd40, 10'd50};
        bus.req      = 2'b01;
        @(negedge clk25mhz);
        bus.req = 2'b00;
        check_timed_move(2'b01, 10'd50, 1'b1);
        @(negedge clk25mhz);
        bus.req = 2'b00;
        check_timed_move(2'b10, 10'd40, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
